// File: rtl/jump_trace_pkg.sv
// Shared types and helpers for the jump-trace encoder: address width, record layout, sequential test.
package jump_trace_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int INSTR_STEP_DEF = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] src;
        logic [ADDR_W_DEF-1:0] dst;
    } jump_rec_t;

    // Wraps modulo 2^ADDR_W_DEF, so all-ones-minus-3 followed by 0 is sequential.
    function automatic logic is_sequential(
        input logic [ADDR_W_DEF-1:0] prev,
        input logic [ADDR_W_DEF-1:0] cur,
        input logic [ADDR_W_DEF-1:0] step = ADDR_W_DEF'(INSTR_STEP_DEF)
    );
        return cur == prev + step;
    endfunction

endpackage

// File: rtl/jump_trace_fifo.sv
// Synchronous FIFO of jump records; extra pointer MSB distinguishes full from empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module jump_trace_fifo
    import jump_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  jump_rec_t i_data,
    input  logic      i_pop,
    output jump_rec_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    jump_rec_t        r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];

    // NOTE: storage is deliberately not reset; the empty flag gates o_data so stale entries never escape.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

    // NOTE: non-blocking assignments, so both pointers update from their pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/jump_trace_encoder.sv
// Watches the fetch address stream, turns non-sequential transitions into {src,dst} records.
// Optional saturating jump/drop counters when JUMP_TRACE_STATS_EN is defined. ADDR_W must equal ADDR_W_DEF.
module jump_trace_encoder
    import jump_trace_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int INSTR_STEP = INSTR_STEP_DEF,
    parameter int DEPTH      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_instr_addr,
    input  logic              i_instr_valid,
    output logic              o_rec_valid,
    input  logic              i_rec_ready,
    output logic [ADDR_W-1:0] o_rec_src,
    output logic [ADDR_W-1:0] o_rec_dst,
    output logic              o_overflow
`ifdef JUMP_TRACE_STATS_EN
    ,
    output logic [15:0]       o_jump_count,
    output logic [15:0]       o_drop_count
`endif
);

    logic [ADDR_W-1:0] r_prev_addr;
    logic              r_prev_vld;
    logic              r_overflow;
    logic              w_jump;
    logic              w_pop;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    jump_rec_t         w_rec;
    jump_rec_t         w_head;

    // NOTE: default assignment first keeps this block purely combinational.
    always_comb begin
        w_jump = 1'b0;
        if (i_instr_valid && r_prev_vld) begin
            w_jump = (i_instr_addr != r_prev_addr) &&
                     !is_sequential(r_prev_addr, i_instr_addr, ADDR_W'(INSTR_STEP));
        end
    end

    assign w_rec.src = r_prev_addr;
    assign w_rec.dst = i_instr_addr;
    assign w_pop     = o_rec_valid & i_rec_ready;
    assign w_drop    = w_jump & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_addr <= '0;
            r_prev_vld  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (i_instr_valid) begin
                r_prev_addr <= i_instr_addr;
                r_prev_vld  <= 1'b1;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    jump_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_jump),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_rec_valid = ~w_empty;
    assign o_rec_src   = w_head.src;
    assign o_rec_dst   = w_head.dst;
    assign o_overflow  = r_overflow;

`ifdef JUMP_TRACE_STATS_EN
    logic [15:0] r_jump_count;
    logic [15:0] r_drop_count;

    // Dropped jumps still count as detected jumps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_jump_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_jump && r_jump_count != 16'hFFFF) r_jump_count <= r_jump_count + 16'd1;
            if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_jump_count = r_jump_count;
    assign o_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_jump_trace_encoder.sv
// Self-checking bench for jump_trace_encoder: vector table, corner-case sequences, random vs queue model.
module tb_jump_trace_encoder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ivld;
    logic        rdy;
    logic [31:0] addr;
    logic        ovld;
    logic [31:0] src;
    logic [31:0] dst;
    logic        ovf;
`ifdef JUMP_TRACE_STATS_EN
    logic [15:0] jump_count;
    logic [15:0] drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jump_trace_encoder #(
        .ADDR_W     (32),
        .INSTR_STEP (4),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr_addr  (addr),
        .i_instr_valid (ivld),
        .o_rec_valid   (ovld),
        .i_rec_ready   (rdy),
        .o_rec_src     (src),
        .o_rec_dst     (dst),
        .o_overflow    (ovf)
`ifdef JUMP_TRACE_STATS_EN
        ,
        .o_jump_count  (jump_count),
        .o_drop_count  (drop_count)
`endif
    );

    // Reference model: a plain queue of records plus the last-seen address.
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
    } rec_t;

    rec_t        m_q[$];
    logic [31:0] m_prev;
    logic        m_pvld;
    logic        m_ovf;
    int          m_jumps;
    int          m_drops;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] addr;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_src;
        logic [31:0] e_dst;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic [31:0] a, logic rd,
                                logic ev, logic [31:0] es, logic [31:0] ed, logic eo);
        vec_t t;
        t.rst = r; t.vld = v; t.addr = a; t.rdy = rd;
        t.e_vld = ev; t.e_src = es; t.e_dst = ed; t.e_ovf = eo;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        logic pop;
        logic jump;
        if (rst) begin
            m_q.delete();
            m_prev  = '0;
            m_pvld  = 1'b0;
            m_ovf   = 1'b0;
            m_jumps = 0;
            m_drops = 0;
        end else begin
            pop  = (m_q.size() > 0) && rdy;
            jump = ivld && m_pvld && (addr != m_prev) && (addr != m_prev + 32'd4);
            if (pop) void'(m_q.pop_front());
            if (jump) begin
                if (m_jumps < 65535) m_jumps++;
                if (m_q.size() < DEPTH) m_q.push_back('{m_prev, addr});
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (ivld) begin
                m_prev = addr;
                m_pvld = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model(string tag);
        check({tag, " valid"}, 32'(ovld), 32'(m_q.size() > 0));
        check({tag, " overflow"}, 32'(ovf), 32'(m_ovf));
        if (m_q.size() > 0) begin
            check({tag, " src"}, src, m_q[0].src);
            check({tag, " dst"}, dst, m_q[0].dst);
        end
`ifdef JUMP_TRACE_STATS_EN
        check({tag, " jump_count"}, 32'(jump_count), 32'(m_jumps));
        check({tag, " drop_count"}, 32'(drop_count), 32'(m_drops));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int rdy_pct;
        int sel;

        rst = 1'b1; ivld = 1'b0; rdy = 1'b1; addr = '0;

        // Reset, sequential run, stall then jump, wraparound, held-prev across invalid cycles.
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h100,      1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h104,      1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h108,      1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h500,      0, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h500,      0, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h500,      0, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h250,      0, 1, 32'h500, 32'h250,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h500, 32'h250,  0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h0,        1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h4000,     0, 1, 32'h0,   32'h4000, 0));
        vecs.push_back(mk(0, 0, 32'h9999,     1, 0, 32'h0,   32'h0,    0));
        vecs.push_back(mk(0, 1, 32'h4004,     1, 0, 32'h0,   32'h0,    0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; ivld = vecs[i].vld; addr = vecs[i].addr; rdy = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d valid", i), 32'(ovld), 32'(vecs[i].e_vld));
            check($sformatf("vec%0d overflow", i), 32'(ovf), 32'(vecs[i].e_ovf));
            if (vecs[i].e_vld || vecs[i].rst) begin
                check($sformatf("vec%0d src", i), src, vecs[i].e_src);
                check($sformatf("vec%0d dst", i), dst, vecs[i].e_dst);
            end
        end

        // Overflow: 9 jumps into an 8-deep FIFO, then drain in order.
        rst = 1'b1; ivld = 1'b0; rdy = 1'b0; tick(); rst = 1'b0;
        ivld = 1'b1; addr = 32'h9000; tick();
        for (int k = 1; k <= 9; k++) begin
            addr = (k % 2) ? 32'h700 : 32'h9000;
            tick();
            if (k == 8) check("ovf before 9th jump", 32'(ovf), 32'd0);
        end
        check("ovf after 9th jump", 32'(ovf), 32'd1);
        check("valid when full", 32'(ovld), 32'd1);
        ivld = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain%0d src", k), src, (k % 2 == 0) ? 32'h9000 : 32'h700);
            check($sformatf("drain%0d dst", k), dst, (k % 2 == 0) ? 32'h700 : 32'h9000);
            tick();
        end
        check("drained valid", 32'(ovld), 32'd0);
        check("ovf sticky after drain", 32'(ovf), 32'd1);

        // Reset with records queued flushes them and clears overflow; next address only seeds.
        rdy = 1'b0; ivld = 1'b1;
        addr = 32'h9000; tick();
        addr = 32'h700;  tick();
        addr = 32'h9000; tick();
        check("3 queued valid", 32'(ovld), 32'd1);
        ivld = 1'b0; rst = 1'b1; rdy = 1'b1; tick();
        rst = 1'b0; rdy = 1'b0;
        check("post-reset valid", 32'(ovld), 32'd0);
        check("post-reset ovf", 32'(ovf), 32'd0);
`ifdef JUMP_TRACE_STATS_EN
        check("post-reset jump_count", 32'(jump_count), 32'd0);
        check("post-reset drop_count", 32'(drop_count), 32'd0);
`endif
        ivld = 1'b1; addr = 32'h600; tick();
        check("seed 0x600 valid", 32'(ovld), 32'd0);
        addr = 32'h604; tick();
        check("seq after seed valid", 32'(ovld), 32'd0);
        addr = 32'h1000; tick();
        check("jump after seed src", src, 32'h604);
        check("jump after seed dst", dst, 32'h1000);

        // Full FIFO with simultaneous push and pop: nothing dropped.
        rst = 1'b1; ivld = 1'b0; rdy = 1'b0; tick(); rst = 1'b0;
        ivld = 1'b1; addr = 32'h9000; tick();
        for (int k = 1; k <= 8; k++) begin
            addr = (k % 2) ? 32'h700 : 32'h9000;
            tick();
        end
        check("full head src", src, 32'h9000);
        addr = 32'h700; rdy = 1'b1; tick();
        check("push+pop ovf", 32'(ovf), 32'd0);
        check("push+pop head src", src, 32'h700);
        check("push+pop head dst", dst, 32'h9000);
        ivld = 1'b0;
        pops = 0;
        for (int c = 0; c < 20 && ovld; c++) begin
            pops++;
            tick();
        end
        check("occupancy after push+pop", 32'(pops), 32'd8);
        check("ovf after push+pop drain", 32'(ovf), 32'd0);

        // Randomised traffic against the queue model.
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) rdy_pct = (n / 500 % 3 == 0) ? 10 : ((n / 500 % 3 == 1) ? 90 : 50);
            rst  = ($urandom_range(0, 199) == 0);
            ivld = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 99) < rdy_pct);
            sel  = $urandom_range(0, 9);
            if (sel <= 4)      addr = m_prev + 32'd4;
            else if (sel <= 6) addr = m_prev;
            else if (sel == 7) addr = 32'hFFFFFFFC;
            else if (sel == 8) addr = $urandom;
            else               addr = 32'($urandom_range(0, 15)) << 2;
            tick();
            check_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
